// File: rtl/avalon_mem_arbiter_if.sv
// Bus bundle for the instruction/data to unified-memory arbiter.
// Carries the fetch port (i_*), the load/store port (d_*) and the single
// Avalon-MM port towards memory (m_*). The arbiter is the Avalon master
// towards memory and takes the "master" view; the core and memory
// environment take the "slave" view.
interface avalon_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester (read-only)
    logic [ADDR_W-1:0]   i_address;
    logic                i_read;
    logic                i_waitrequest;
    logic [DATA_W-1:0]   i_readdata;

    // Data requester (read/write)
    logic [ADDR_W-1:0]   d_address;
    logic                d_read;
    logic                d_write;
    logic [DATA_W-1:0]   d_writedata;
    logic [DATA_W/8-1:0] d_byteenable;
    logic                d_waitrequest;
    logic [DATA_W-1:0]   d_readdata;

    // Shared memory port
    logic [ADDR_W-1:0]   m_address;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_waitrequest;
    logic [DATA_W-1:0]   m_readdata;

    modport master (
        input  i_address, i_read,
        output i_waitrequest, i_readdata,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata
    );

    modport slave (
        output i_address, i_read,
        input  i_waitrequest, i_readdata,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata
    );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Two-requester arbiter sharing one Avalon-MM memory port between
// instruction fetch (I) and data load/store (D). D has fixed priority,
// but after STARVE_LIMIT consecutive D grants taken while I was waiting,
// I is forced through. A grant is held until memory drops waitrequest,
// and memory-side outputs are decoded from the registered state only.
module avalon_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_mem_arbiter_if.master  bus,
    output logic                  proto_err
);
    localparam int         BE_W  = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starveCnt_q, starveCnt_d;
    logic       dIsWrite_q, dIsWrite_d;
    logic       protoErr_q, protoErr_d;

    logic iReq;
    logic dAny;
    logic dIllegal;
    logic dReq;
    logic starved;
    logic dHeld;

    assign iReq     = bus.i_read;
    assign dAny     = bus.d_read | bus.d_write;
    assign dIllegal = bus.d_read & bus.d_write;
    assign dReq     = dAny & ~dIllegal;
    assign starved  = (starveCnt_q == LIMIT);
    // The D operation latched at grant time must stay asserted until done.
    assign dHeld    = dIsWrite_q ? bus.d_write : bus.d_read;

    // State, starvation counter, granted D operation and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starveCnt_q <= 4'd0;
            dIsWrite_q  <= 1'b0;
            protoErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            dIsWrite_q  <= dIsWrite_d;
            protoErr_q  <= protoErr_d;
        end
    end

    // Arbitration in IDLE, completion or protocol-violation exit in a grant.
    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        dIsWrite_d  = dIsWrite_q;
        protoErr_d  = protoErr_q;
        unique case (state_q)
            IDLE: begin
                if (dIllegal) begin
                    protoErr_d = 1'b1;
                end
                if (dReq && iReq && starved) begin
                    state_d     = GNT_I;
                    starveCnt_d = 4'd0;
                end else if (dReq) begin
                    state_d    = GNT_D;
                    dIsWrite_d = bus.d_write;
                    if (!iReq) begin
                        starveCnt_d = 4'd0;
                    end else if (!starved) begin
                        starveCnt_d = starveCnt_q + 4'd1;
                    end
                end else if (iReq) begin
                    state_d     = GNT_I;
                    starveCnt_d = 4'd0;
                end
            end
            GNT_I: begin
                if (!iReq) begin
                    state_d    = IDLE;
                    protoErr_d = 1'b1;
                end else if (!bus.m_waitrequest) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (!dHeld) begin
                    state_d    = IDLE;
                    protoErr_d = 1'b1;
                end else if (!bus.m_waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port and requester stalls, decoded from the grant state only.
    always_comb begin
        bus.m_address     = {ADDR_W{1'b0}};
        bus.m_read        = 1'b0;
        bus.m_write       = 1'b0;
        bus.m_writedata   = {DATA_W{1'b0}};
        bus.m_byteenable  = {BE_W{1'b0}};
        bus.i_waitrequest = 1'b1;
        bus.d_waitrequest = 1'b1;
        unique case (state_q)
            GNT_I: begin
                bus.m_address     = bus.i_address;
                bus.m_read        = bus.i_read;
                bus.m_byteenable  = {BE_W{1'b1}};
                bus.i_waitrequest = bus.m_waitrequest;
            end
            GNT_D: begin
                bus.m_address     = bus.d_address;
                bus.m_read        = bus.d_read;
                bus.m_write       = bus.d_write;
                bus.m_writedata   = bus.d_writedata;
                bus.m_byteenable  = bus.d_byteenable;
                bus.d_waitrequest = bus.m_waitrequest;
            end
            default: begin
            end
        endcase
    end

    assign bus.i_readdata = bus.m_readdata;
    assign bus.d_readdata = bus.m_readdata;
    assign proto_err      = protoErr_q;
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: a cycle table for the basic
// transfers, hand sequences for starvation, protocol errors and reset, and
// a randomized run checked against a transaction-level memory model.
module tb_avalon_mem_arbiter;
    localparam int          ADDR_W       = 32;
    localparam int          DATA_W       = 32;
    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] I_ADDR       = 32'hBFC00000;
    localparam logic [31:0] D_ADDR       = 32'h00000010;
    localparam logic [31:0] W_DATA       = 32'hDEADBEEF;
    localparam logic [3:0]  W_BE         = 4'b0011;
    localparam logic [3:0]  CTL_IDLE     = 4'b0011;

    typedef struct {
        logic [3:0]  in;
        logic [3:0]  ctl;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chkW;
        logic [31:0] wdata;
    } vec_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        memReinit = 1'b0;
    logic        protoErr;
    int          total     = 0;
    int          bad       = 0;
    logic [31:0] slaveMem [0:63];
    logic [31:0] refMem   [0:63];
    vec_t        vecs     [0:13];

    avalon_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master),
        .proto_err(protoErr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int idx);
        return 32'hC0DE0000 + 32'(idx) * 32'h00000111;
    endfunction

    // Memory slave: zero-wait read data, byte-lane writes on accepted cycles.
    always @(posedge clk) begin
        if (memReinit) begin
            for (int k = 0; k < 64; k++) slaveMem[k] <= initWord(k);
        end else if (bus.m_write && !bus.m_waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (bus.m_byteenable[b])
                    slaveMem[bus.m_address[7:2]][8*b +: 8] <= bus.m_writedata[8*b +: 8];
        end
    end

    assign bus.m_readdata = slaveMem[bus.m_address[7:2]];

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_address     = '0;
        bus.d_writedata   = '0;
        bus.d_byteenable  = '0;
        bus.m_waitrequest = 1'b0;
    endtask

    task automatic applyReset(input bit reinit);
        reset     = 1'b1;
        memReinit = reinit;
        tick();
        memReinit = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.i_address     = I_ADDR;
        bus.d_address     = D_ADDR;
        bus.d_writedata   = W_DATA;
        bus.d_byteenable  = W_BE;
        bus.i_read        = v.in[3];
        bus.d_read        = v.in[2];
        bus.d_write       = v.in[1];
        bus.m_waitrequest = v.in[0];
    endtask

    function automatic vec_t mkVec(input logic [3:0] in, input logic [3:0] ctl, input logic [31:0] addr,
                                   input logic [3:0] be, input logic chkW, input logic [31:0] wdata);
        vec_t v;
        v.in = in; v.ctl = ctl; v.addr = addr; v.be = be; v.chkW = chkW; v.wdata = wdata;
        return v;
    endfunction

    // One row per clock: {i_read,d_read,d_write,m_waitrequest} in,
    // {m_read,m_write,i_waitrequest,d_waitrequest} expected.
    task automatic runTable();
        logic [31:0] w;
        vecs[0]  = mkVec(4'b1000, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        vecs[1]  = mkVec(4'b1000, 4'b1001, I_ADDR, 4'hF, 1'b0, 32'h0);
        vecs[2]  = mkVec(4'b0000, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        vecs[3]  = mkVec(4'b1100, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        vecs[4]  = mkVec(4'b1100, 4'b1010, D_ADDR, W_BE, 1'b1, W_DATA);
        vecs[5]  = mkVec(4'b1000, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        vecs[6]  = mkVec(4'b1000, 4'b1001, I_ADDR, 4'hF, 1'b0, 32'h0);
        vecs[7]  = mkVec(4'b0000, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        vecs[8]  = mkVec(4'b0011, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        vecs[9]  = mkVec(4'b0011, 4'b0111, D_ADDR, W_BE, 1'b1, W_DATA);
        vecs[10] = mkVec(4'b0011, 4'b0111, D_ADDR, W_BE, 1'b1, W_DATA);
        vecs[11] = mkVec(4'b0011, 4'b0111, D_ADDR, W_BE, 1'b1, W_DATA);
        vecs[12] = mkVec(4'b0010, 4'b0110, D_ADDR, W_BE, 1'b1, W_DATA);
        vecs[13] = mkVec(4'b0000, CTL_IDLE, 32'h0, 4'h0, 1'b1, 32'h0);
        clearInputs();
        applyReset(1'b1);
        for (int r = 0; r < 14; r++) begin
            applyStimulus(vecs[r]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ctrl", r),
                        {23'd0, bus.m_read, bus.m_write, bus.i_waitrequest, bus.d_waitrequest,
                         bus.m_address, bus.m_byteenable, protoErr},
                        {23'd0, vecs[r].ctl, vecs[r].addr, vecs[r].be, 1'b0});
            w = initWord(int'(vecs[r].addr[7:2]));
            checkOutput($sformatf("vec%0d_rdata", r), {bus.i_readdata, bus.d_readdata}, {w, w});
            if (vecs[r].chkW)
                checkOutput($sformatf("vec%0d_wdata", r), bus.m_writedata, vecs[r].wdata);
            tick();
        end
    endtask

    // Both requesters held busy: D wins until I has waited STARVE_LIMIT grants.
    task automatic runStarveSeq();
        logic [9:0] order;
        int n;
        int both;
        order = '0; n = 0; both = 0;
        clearInputs();
        applyReset(1'b0);
        bus.i_address = I_ADDR;
        bus.d_address = D_ADDR;
        bus.i_read    = 1'b1;
        bus.d_read    = 1'b1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (!bus.i_waitrequest && !bus.d_waitrequest) both++;
            if (!bus.i_waitrequest) begin
                order[n] = 1'b1; n++;
            end else if (!bus.d_waitrequest) begin
                order[n] = 1'b0; n++;
            end
            tick();
        end
        checkOutput("starve_done_count", 64'(n), 64'd10);
        checkOutput("starve_order", 64'(order), 64'(10'b1000010000));
        checkOutput("starve_exclusive", 64'(both), 64'd0);
        clearInputs();
        tick();
    endtask

    // Dropped request mid-transfer and illegal read+write, then normal I traffic.
    task automatic runProtoSeq();
        bit          got;
        logic [31:0] data;
        int          iDone;
        int          dLow;
        clearInputs();
        applyReset(1'b0);
        bus.d_address     = D_ADDR;
        bus.d_read        = 1'b1;
        bus.m_waitrequest = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("drop_granted", {bus.m_read, bus.d_waitrequest, protoErr}, 3'b110);
        bus.d_read = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("drop_flag", {bus.m_read, bus.m_write, bus.d_waitrequest, protoErr}, 4'b0011);
        bus.i_address     = I_ADDR;
        bus.i_read        = 1'b1;
        bus.m_waitrequest = 1'b0;
        got = 1'b0; data = '0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (!bus.i_waitrequest) begin
                got = 1'b1; data = bus.i_readdata;
            end
            tick();
        end
        bus.i_read = 1'b0;
        checkOutput("proto_i_done", 64'(got), 64'd1);
        checkOutput("proto_i_data", data, initWord(0));
        tick();
        @(negedge clk);
        checkOutput("proto_sticky", protoErr, 1'b1);
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.i_read  = 1'b1;
        iDone = 0; dLow = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!bus.d_waitrequest) dLow++;
            if (!bus.i_waitrequest) iDone++;
            tick();
        end
        checkOutput("illegal_d_never_served", 64'(dLow), 64'd0);
        checkOutput("illegal_i_served", 64'(iDone), 64'd6);
        checkOutput("illegal_flag", protoErr, 1'b1);
        clearInputs();
        tick();
        tick();
    endtask

    // Reset during a stalled D grant with the starvation count at its limit.
    task automatic runResetSeq();
        int nD;
        bit sawI;
        bit firstD;
        bit got;
        bus.i_address = I_ADDR;
        bus.d_address = D_ADDR;
        bus.i_read    = 1'b1;
        bus.d_read    = 1'b1;
        bus.m_waitrequest = 1'b0;
        nD = 0; sawI = 1'b0;
        for (int c = 0; c < 40 && nD < 3; c++) begin
            @(negedge clk);
            if (!bus.d_waitrequest) nD++;
            if (!bus.i_waitrequest) sawI = 1'b1;
            tick();
        end
        checkOutput("rst_pre_d_count", {63'(nD), sawI}, {63'd3, 1'b0});
        bus.m_waitrequest = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst_pre_state", {bus.m_read, bus.i_waitrequest, bus.d_waitrequest, protoErr}, 4'b1111);
        reset = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst_outputs",
                    {bus.m_read, bus.m_write, bus.d_waitrequest, bus.i_waitrequest, protoErr}, 5'b00110);
        reset = 1'b0;
        bus.m_waitrequest = 1'b0;
        got = 1'b0; firstD = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (!bus.d_waitrequest || !bus.i_waitrequest) begin
                got = 1'b1; firstD = !bus.d_waitrequest;
            end
            tick();
        end
        checkOutput("rst_cnt_cleared", {got, firstD}, 2'b11);
        clearInputs();
        tick();
    endtask

    // Random traffic against a word-array memory model and a starvation bound.
    task automatic runRandom();
        bit          iPend, dPend, dWr, iDone, dDone, abort;
        int          iIdx, dIdx, dWhileI, iAge, dAge, nI, nD;
        logic [31:0] dData;
        logic [3:0]  dBe;
        iPend = 0; dPend = 0; dWr = 0; abort = 0;
        iIdx = 0; dIdx = 0; dWhileI = 0; iAge = 0; dAge = 0; nI = 0; nD = 0;
        dData = '0; dBe = '0;
        for (int k = 0; k < 64; k++) refMem[k] = initWord(k);
        clearInputs();
        applyReset(1'b1);
        for (int c = 0; c < 3000 && !abort; c++) begin
            if (!iPend && $urandom_range(0, 99) < 45) begin
                iPend = 1; iIdx = $urandom_range(0, 15); dWhileI = 0; iAge = 0;
            end
            if (!dPend && $urandom_range(0, 99) < 55) begin
                dPend = 1; dWr = 1'($urandom_range(0, 1)); dIdx = $urandom_range(0, 15);
                dData = $urandom; dBe = 4'($urandom_range(0, 15)); dAge = 0;
            end
            bus.i_read        = iPend;
            bus.i_address     = 32'(iIdx) << 2;
            bus.d_read        = dPend && !dWr;
            bus.d_write       = dPend && dWr;
            bus.d_address     = 32'(dIdx) << 2;
            bus.d_writedata   = dData;
            bus.d_byteenable  = dBe;
            bus.m_waitrequest = ($urandom_range(0, 99) < 35);
            @(negedge clk);
            iDone = iPend && !bus.i_waitrequest;
            dDone = dPend && !bus.d_waitrequest;
            if (iDone || dDone)
                checkOutput("rand_exclusive", {iDone, dDone} == 2'b11, 1'b0);
            if (iDone) begin
                nI++;
                checkOutput("rand_i_bus", {bus.m_address, bus.m_read, bus.m_write},
                            {32'(iIdx) << 2, 1'b1, 1'b0});
                checkOutput("rand_i_data", bus.i_readdata, refMem[iIdx]);
                total++;
                if (dWhileI > STARVE_LIMIT + 1) begin
                    bad++;
                    $display("[TB] FAIL rand_i_starve: got %0d D transfers want at most %0d",
                             dWhileI, STARVE_LIMIT + 1);
                end
                iPend = 0;
            end
            if (dDone) begin
                nD++;
                checkOutput("rand_d_bus", {bus.m_address, bus.m_read, bus.m_write},
                            {32'(dIdx) << 2, !dWr, dWr});
                if (dWr) begin
                    checkOutput("rand_d_wbus", {bus.m_writedata, bus.m_byteenable}, {dData, dBe});
                    for (int b = 0; b < 4; b++)
                        if (dBe[b]) refMem[dIdx][8*b +: 8] = dData[8*b +: 8];
                end else begin
                    checkOutput("rand_d_data", bus.d_readdata, refMem[dIdx]);
                end
                if (iPend) dWhileI++;
                dPend = 0;
            end
            if (iPend) iAge++;
            if (dPend) dAge++;
            if (iAge > 200 || dAge > 200) begin
                total++; bad++;
                $display("[TB] FAIL rand_timeout: got iAge=%0d dAge=%0d want at most 200", iAge, dAge);
                abort = 1;
            end
            tick();
        end
        checkOutput("rand_proto_clean", protoErr, 1'b0);
        checkOutput("rand_progress", {nI > 20, nD > 20}, 2'b11);
        clearInputs();
        tick();
    endtask

    initial begin
        clearInputs();
        runTable();
        runStarveSeq();
        runProtoSeq();
        runResetSeq();
        runRandom();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
